// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives the buffer enables/flushes and the PC enable,
// tracks RUN/MEM_WAIT/HALT with a data-memory timeout and performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        reg_ren_D,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic        MemRead_E,
    input  logic [4:0]  Rd_E,
    input  logic        PCSrc_E,
    input  logic        mem_access_M,
    input  logic        dmem_ack,
    input  logic        ebreak_W,
    output logic        en_PC,
    output logic        valid_F,
    output logic        valid_D,
    output logic        valid_E,
    output logic        valid_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        halted,
    output logic        mem_err,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt
);

    localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WCW-1:0]   wait_cnt_r, wait_nxt_s;
    logic             mem_err_r, mem_err_nxt_s;
    logic [31:0]      cyc_cnt_r, stall_cnt_r;
    logic             freeze_s, load_use_s;
    logic [6:0]       ctl_s;

    assign freeze_s   = mem_access_M & ~dmem_ack;
    assign load_use_s = MemRead_E & reg_ren_D & (Rd_E != 5'd0) &
                        ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));

    // Enable/flush decode: {en_PC, valid_F, valid_D, valid_E, valid_M, flush_D, flush_E}
    always_comb begin
        ctl_s = 7'b0000000;
        if (!rst || (state_r == ST_HALT)) begin
            ctl_s = 7'b0000000;
        end else if (freeze_s) begin
            ctl_s = 7'b0000000;
        end else if (PCSrc_E) begin
            ctl_s = 7'b1111111;
        end else if (load_use_s) begin
            ctl_s = 7'b0011101;
        end else if (!imem_ready) begin
            ctl_s = 7'b0111110;
        end else begin
            ctl_s = 7'b1111100;
        end
    end

    assign {en_PC, valid_F, valid_D, valid_E, valid_M, flush_D, flush_E} = ctl_s;

    // Next-state logic; a held ebreak in W is taken as soon as the freeze clears
    always_comb begin
        state_nxt_s   = state_r;
        wait_nxt_s    = wait_cnt_r;
        mem_err_nxt_s = mem_err_r;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                    wait_nxt_s  = WCW'(1);
                end else if (ebreak_W) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (freeze_s) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_nxt_s   = ST_HALT;
                        mem_err_nxt_s = 1'b1;
                    end else begin
                        wait_nxt_s = wait_cnt_r + WCW'(1);
                    end
                end else if (ebreak_W) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State, timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            mem_err_r  <= mem_err_nxt_s;
        end
    end

    // Performance counters, frozen in HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_r   <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else if (state_r != ST_HALT) begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
            if (!en_PC) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            cyc_cnt_r   <= cyc_cnt_r;
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign halted    = (state_r == ST_HALT);
    assign mem_err   = mem_err_r;
    assign cyc_cnt   = cyc_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with a short memory timeout.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready, reg_ren_D, MemRead_E, PCSrc_E;
    logic        mem_access_M, dmem_ack, ebreak_W;
    logic [4:0]  Rs1_D, Rs2_D, Rd_E;
    logic        en_PC, valid_F, valid_D, valid_E, valid_M, flush_D, flush_E;
    logic        halted, mem_err;
    logic [31:0] cyc_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cyc   = 0;
    int exp_stall = 0;

    localparam logic [6:0] V_ZERO = 7'b0000000;
    localparam logic [6:0] V_RUN  = 7'b1111100;
    localparam logic [6:0] V_LU   = 7'b0011101;
    localparam logic [6:0] V_BR   = 7'b1111111;
    localparam logic [6:0] V_FW   = 7'b0111110;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .reg_ren_D(reg_ren_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .MemRead_E(MemRead_E), .Rd_E(Rd_E),
        .PCSrc_E(PCSrc_E), .mem_access_M(mem_access_M), .dmem_ack(dmem_ack),
        .ebreak_W(ebreak_W), .en_PC(en_PC), .valid_F(valid_F), .valid_D(valid_D),
        .valid_E(valid_E), .valid_M(valid_M), .flush_D(flush_D), .flush_E(flush_E),
        .halted(halted), .mem_err(mem_err), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, en_PC, valid_F, valid_D, valid_E, valid_M, flush_D, flush_E}, {25'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cyc"}, cyc_cnt, exp_cyc);
        chk({tag, "_stall"}, stall_cnt, exp_stall);
    endtask

    task automatic idle();
        imem_ready = 1'b1; reg_ren_D = 1'b0; MemRead_E = 1'b0; PCSrc_E = 1'b0;
        mem_access_M = 1'b0; dmem_ack = 1'b0; ebreak_W = 1'b0;
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rd_E = 5'd0;
    endtask

    // one clock in RUN/MEM_WAIT; stalled tells whether en_PC is expected low
    task automatic tick(input bit stalled);
        @(posedge clk); #1;
        exp_cyc++;
        if (stalled) exp_stall++;
    endtask

    task automatic tick_halt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        #1;
        rst = 1'b1;
        exp_cyc = 0;
        exp_stall = 0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        chk_vec("reset_vec", V_ZERO);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
        chk_cnt("reset");
        #10 rst = 1'b1;
        #1 chk_vec("idle_run", V_RUN);
        tick(1'b0);

        // load-use through Rs2
        MemRead_E = 1'b1; Rd_E = 5'd5; Rs2_D = 5'd5; Rs1_D = 5'd3; reg_ren_D = 1'b1;
        #1 chk_vec("load_use_rs2", V_LU);
        tick(1'b1);
        chk_cnt("after_load_use");
        Rd_E = 5'd0; Rs2_D = 5'd0;
        #1 chk_vec("load_use_x0", V_RUN);
        tick(1'b0);
        Rd_E = 5'd7; Rs1_D = 5'd7; reg_ren_D = 1'b0;
        #1 chk_vec("load_use_noren", V_RUN);
        reg_ren_D = 1'b1;
        #1 chk_vec("load_use_rs1", V_LU);
        tick(1'b1);

        // branch beats load-use and fetch wait
        PCSrc_E = 1'b1; imem_ready = 1'b0;
        #1 chk_vec("branch_prio", V_BR);
        tick(1'b0);
        idle(); imem_ready = 1'b0;
        #1 chk_vec("fetch_wait", V_FW);
        tick(1'b1);
        idle(); mem_access_M = 1'b1; dmem_ack = 1'b1;
        #1 chk_vec("zero_wait_mem", V_RUN);
        tick(1'b0);
        chk_cnt("before_mem_wait");

        // three frozen cycles, then ack
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk_vec("mem_wait_frozen", V_ZERO);
            tick(1'b1);
        end
        dmem_ack = 1'b1; PCSrc_E = 1'b0;
        #1 chk_vec("mem_wait_ack", V_RUN);
        tick(1'b0);
        idle();
        chk_cnt("after_mem_wait");
        chk("mem_wait_no_err", {31'd0, mem_err}, 32'd0);

        // ack arrives on the timeout cycle
        mem_access_M = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1);
        dmem_ack = 1'b1;
        #1 chk_vec("timeout_ack_vec", V_RUN);
        tick(1'b0);
        idle();
        chk("timeout_ack_err", {31'd0, mem_err}, 32'd0);
        chk("timeout_ack_halt", {31'd0, halted}, 32'd0);
        chk_cnt("timeout_ack");

        // ebreak held during a freeze is taken only after the ack
        mem_access_M = 1'b1; ebreak_W = 1'b1;
        tick(1'b1);
        tick(1'b1);
        chk("ebreak_frozen", {31'd0, halted}, 32'd0);
        dmem_ack = 1'b1;
        tick(1'b0);
        mem_access_M = 1'b0; dmem_ack = 1'b0;
        tick_halt();
        chk("ebreak_after_ack", {31'd0, halted}, 32'd1);
        chk_vec("ebreak_after_ack_vec", V_ZERO);

        // async reset in the middle of MEM_WAIT
        do_reset();
        mem_access_M = 1'b1;
        tick(1'b1);
        tick(1'b1);
        #2 rst = 1'b0;
        #1 chk_vec("async_rst_vec", V_ZERO);
        chk("async_rst_cyc", cyc_cnt, 32'd0);
        chk("async_rst_stall", stall_cnt, 32'd0);
        exp_cyc = 0; exp_stall = 0;
        idle();
        rst = 1'b1;
        #1 chk_vec("async_rst_release", V_RUN);

        // timeout without ack
        mem_access_M = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1);
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        chk("timeout_mem_err", {31'd0, mem_err}, 32'd1);
        chk_vec("timeout_vec", V_ZERO);
        chk_cnt("timeout_entry");
        mem_access_M = 1'b0;
        tick_halt();
        tick_halt();
        chk_vec("halt_idle_vec", V_ZERO);
        chk_cnt("halt_frozen");

        // plain ebreak in RUN
        do_reset();
        ebreak_W = 1'b1;
        #1 chk_vec("ebreak_run_vec", V_RUN);
        tick(1'b0);
        chk("ebreak_halted", {31'd0, halted}, 32'd1);
        chk_vec("ebreak_halt_vec", V_ZERO);
        tick_halt();
        chk_cnt("ebreak_halt_cnt");
        chk("ebreak_no_err", {31'd0, mem_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
